// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and sizes for the 4x4 keypad scanner
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } sweep_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with sweep-level debounce
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  output logic                key_strobe,
  output logic                key_pending,
  input  logic                key_ack
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_ROWS-1:0] row_sync;

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [KEY_W-1:0] acc_code_q, acc_code_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  sweep_e           prev_cls_q, prev_cls_d;
  logic [KEY_W-1:0] prev_code_q, prev_code_d;
  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_code_q, key_code_d;
  logic             key_strobe_q, key_strobe_d;
  logic             key_pending_q, key_pending_d;

  logic             sample;
  logic [2:0]       col_hits;
  logic [1:0]       hit_row;
  logic [2:0]       hit_sum;
  logic [1:0]       merged_cnt;
  logic [KEY_W-1:0] merged_code;
  sweep_e           sweep_cls;
  logic             same_result;
  logic             new_key;

  sync_2ff #(
    .WIDTH    (NUM_ROWS),
    .RESET_VAL({NUM_ROWS{1'b1}})
  ) u_row_sync (
    .clk(clk),
    .rst(rst),
    .d_i(row),
    .q_o(row_sync)
  );

  // Fold this column's hits into the sweep; count saturates at 2 (= MULTI).
  always_comb begin
    sample   = (div_q == DIV_LAST);
    col_hits = 3'd0;
    hit_row  = 2'd0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!row_sync[r]) begin
        col_hits = col_hits + 3'd1;
        hit_row  = 2'(r);
      end
    end
    hit_sum     = {1'b0, acc_cnt_q} + col_hits;
    merged_cnt  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    merged_code = (col_hits == 3'd1) ? {hit_row, col_idx_q} : acc_code_q;
    case (merged_cnt)
      2'd0:    sweep_cls = NONE;
      2'd1:    sweep_cls = SINGLE;
      default: sweep_cls = MULTI;
    endcase
    same_result = (sweep_cls == prev_cls_q) &&
                  ((sweep_cls != SINGLE) || (merged_code == prev_code_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      col_idx_q     <= 2'd0;
      acc_cnt_q     <= 2'd0;
      acc_code_q    <= '0;
      deb_cnt_q     <= '0;
      prev_cls_q    <= NONE;
      prev_code_q   <= '0;
      state_q       <= RELEASED;
      key_code_q    <= '0;
      key_strobe_q  <= 1'b0;
      key_pending_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      col_idx_q     <= col_idx_d;
      acc_cnt_q     <= acc_cnt_d;
      acc_code_q    <= acc_code_d;
      deb_cnt_q     <= deb_cnt_d;
      prev_cls_q    <= prev_cls_d;
      prev_code_q   <= prev_code_d;
      state_q       <= state_d;
      key_code_q    <= key_code_d;
      key_strobe_q  <= key_strobe_d;
      key_pending_q <= key_pending_d;
    end
  end

  always_comb begin
    div_d        = sample ? '0 : div_q + DIV_ONE;
    col_idx_d    = col_idx_q;
    acc_cnt_d    = acc_cnt_q;
    acc_code_d   = acc_code_q;
    deb_cnt_d    = deb_cnt_q;
    prev_cls_d   = prev_cls_q;
    prev_code_d  = prev_code_q;
    state_d      = state_q;
    key_code_d   = key_code_q;
    key_strobe_d = 1'b0;
    new_key      = 1'b0;

    if (sample) begin
      col_idx_d  = col_idx_q + 2'd1;
      acc_cnt_d  = merged_cnt;
      acc_code_d = merged_code;
      if (col_idx_q == 2'(NUM_COLS - 1)) begin
        acc_cnt_d   = 2'd0;
        acc_code_d  = '0;
        prev_cls_d  = sweep_cls;
        prev_code_d = merged_code;
        if (sweep_cls == MULTI)
          deb_cnt_d = '0;
        else if (same_result)
          deb_cnt_d = (deb_cnt_q == CNT_MAX) ? CNT_MAX : deb_cnt_q + CNT_ONE;
        else
          deb_cnt_d = CNT_ONE;

        // Saturated count with an unchanged key must not re-strobe.
        if ((sweep_cls != MULTI) && (deb_cnt_d == CNT_MAX)) begin
          case (state_q)
            RELEASED: begin
              if (sweep_cls == SINGLE) begin
                state_d = PRESSED;
                new_key = 1'b1;
              end
            end
            PRESSED: begin
              if (sweep_cls == NONE)
                state_d = RELEASED;
              else if (merged_code != key_code_q)
                new_key = 1'b1;
            end
            default: state_d = RELEASED;
          endcase
        end
      end
    end

    if (new_key) begin
      key_code_d   = merged_code;
      key_strobe_d = 1'b1;
    end
    // An ack landing on the strobe cycle belongs to the previous key.
    key_pending_d = new_key | (key_pending_q & ~(key_ack & ~key_strobe_q));
  end

  always_comb begin
    col         = ~(4'b0001 << col_idx_q);
    key_valid   = (state_q == PRESSED);
    key_code    = key_code_q;
    key_strobe  = key_strobe_q;
    key_pending = key_pending_q;
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - randomized self-checking bench for keypad_scan
module tb_keypad_scan;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 3;
  localparam int SWEEP          = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_strobe;
  logic        key_pending;
  logic        key_ack = 1'b0;
  logic [15:0] key_mask = 16'h0000;

  int vectors     = 0;
  int miscompares = 0;
  int obs_strobes = 0;

  bit         m_pressed;
  logic [3:0] m_code;
  bit         m_pending;
  int         m_prev_cls;
  int         m_prev_code;
  int         m_cnt;
  bit         m_strobe_now;

  keypad_scan #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row        (row),
    .col        (col),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_strobe (key_strobe),
    .key_pending(key_pending),
    .key_ack    (key_ack)
  );

  always #5 clk = ~clk;

  // Physical matrix: bit r*4+c of the mask shorts row r to column c.
  function automatic logic [3:0] rows_for(input logic [15:0] mask, input logic [3:0] cols);
    logic [3:0] rows;
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c] && !cols[c]) rows[r] = 1'b0;
    return rows;
  endfunction

  assign row = rows_for(key_mask, col);

  task automatic model_reset();
    m_pressed    = 0;
    m_code       = 4'd0;
    m_pending    = 0;
    m_prev_cls   = 0;
    m_prev_code  = 0;
    m_cnt        = 0;
    m_strobe_now = 0;
  endtask

  // Sweep-level reference: classify the held key set, debounce, decide.
  task automatic model_sweep(input logic [15:0] mask);
    int n, cls, code;
    n    = $countones(mask);
    cls  = (n == 0) ? 0 : ((n == 1) ? 1 : 2);
    code = 0;
    for (int i = 0; i < 16; i++) if (mask[i]) code = i;
    m_strobe_now = 0;
    if (cls == 2) begin
      m_cnt      = 0;
      m_prev_cls = 2;
    end else begin
      if (cls == m_prev_cls && (cls == 0 || code == m_prev_code))
        m_cnt = (m_cnt < DEBOUNCE_SCANS) ? m_cnt + 1 : DEBOUNCE_SCANS;
      else
        m_cnt = 1;
      m_prev_cls  = cls;
      m_prev_code = code;
      if (m_cnt == DEBOUNCE_SCANS) begin
        if (cls == 1 && (!m_pressed || code != int'(m_code))) begin
          m_pressed    = 1;
          m_code       = 4'(code);
          m_strobe_now = 1;
          m_pending    = 1;
        end else if (cls == 0 && m_pressed) begin
          m_pressed = 0;
        end
      end
    end
  endtask

  // Entered just after the edge that starts a sweep; leaves just after the next one.
  task automatic do_sweep(input logic [15:0] mask, input logic [15:0] ack_at, input int ncyc);
    logic [3:0] exp_col;
    logic       exp_strobe;
    key_mask = mask;
    for (int k = 0; k < ncyc; k++) begin
      key_ack = ack_at[k];
      @(negedge clk);
      exp_col    = ~(4'b0001 << (k / SCAN_DIV));
      exp_strobe = (k == 0) && m_strobe_now;
      if (col !== exp_col) begin
        $display("FAIL col k=%0d: got %b want %b", k, col, exp_col);
        miscompares++;
      end
      vectors++;
      if (key_strobe !== exp_strobe) begin
        $display("FAIL key_strobe k=%0d: got %b want %b", k, key_strobe, exp_strobe);
        miscompares++;
      end
      vectors++;
      if (key_valid !== m_pressed) begin
        $display("FAIL key_valid k=%0d: got %b want %b", k, key_valid, m_pressed);
        miscompares++;
      end
      vectors++;
      if (key_code !== m_code) begin
        $display("FAIL key_code k=%0d: got %0d want %0d", k, key_code, m_code);
        miscompares++;
      end
      vectors++;
      if (key_pending !== m_pending) begin
        $display("FAIL key_pending k=%0d: got %b want %b", k, key_pending, m_pending);
        miscompares++;
      end
      vectors++;
      if (key_strobe === 1'b1) obs_strobes++;
      if (ack_at[k] && !exp_strobe) m_pending = 0;
      @(posedge clk);
      #1;
    end
    key_ack = 1'b0;
    if (ncyc == SWEEP) model_sweep(mask);
  endtask

  task automatic sweeps(input logic [15:0] mask, input int n);
    for (int i = 0; i < n; i++) do_sweep(mask, 16'h0000, SWEEP);
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    key_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (col !== 4'b1110) begin
      $display("FAIL reset col: got %b want 1110", col);
      miscompares++;
    end
    vectors++;
    if (key_code !== 4'd0) begin
      $display("FAIL reset key_code: got %0d want 0", key_code);
      miscompares++;
    end
    vectors++;
    if (key_valid !== 1'b0) begin
      $display("FAIL reset key_valid: got %b want 0", key_valid);
      miscompares++;
    end
    vectors++;
    if (key_strobe !== 1'b0) begin
      $display("FAIL reset key_strobe: got %b want 0", key_strobe);
      miscompares++;
    end
    vectors++;
    if (key_pending !== 1'b0) begin
      $display("FAIL reset key_pending: got %b want 0", key_pending);
      miscompares++;
    end
    vectors++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_idle();
    test_reset();
    obs_strobes = 0;
    sweeps(16'h0000, 3);
    if (obs_strobes != 0) begin
      $display("FAIL idle strobes: got %0d want 0", obs_strobes);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_single_press();
    test_reset();
    obs_strobes = 0;
    sweeps(16'h0001 << 6, 5);
    if (obs_strobes != 1) begin
      $display("FAIL single strobes: got %0d want 1", obs_strobes);
      miscompares++;
    end
    vectors++;
    if (key_code !== 4'd6 || key_valid !== 1'b1 || key_pending !== 1'b1) begin
      $display("FAIL single outputs: got code=%0d valid=%b pend=%b want 6 1 1",
               key_code, key_valid, key_pending);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_bounce();
    test_reset();
    obs_strobes = 0;
    for (int i = 0; i < 5; i++) sweeps((i % 2 == 0) ? (16'h0001 << 9) : 16'h0000, 1);
    sweeps(16'h0001 << 9, 1);
    if (obs_strobes != 0) begin
      $display("FAIL bounce early strobes: got %0d want 0", obs_strobes);
      miscompares++;
    end
    vectors++;
    sweeps(16'h0001 << 9, 3);
    if (obs_strobes != 1 || key_code !== 4'd9) begin
      $display("FAIL bounce strobes: got %0d code=%0d want 1 code=9", obs_strobes, key_code);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_multi();
    test_reset();
    sweeps(16'h0001 << 5, 4);
    sweeps(16'h0000, 4);
    obs_strobes = 0;
    sweeps(16'h0001 | (16'h0001 << 11), 4);
    if (obs_strobes != 0 || key_code !== 4'd5 || key_valid !== 1'b0) begin
      $display("FAIL multi hold: got strobes=%0d code=%0d valid=%b want 0 5 0",
               obs_strobes, key_code, key_valid);
      miscompares++;
    end
    vectors++;
    sweeps(16'h0001, 4);
    if (obs_strobes != 1 || key_code !== 4'd0) begin
      $display("FAIL multi release: got strobes=%0d code=%0d want 1 0", obs_strobes, key_code);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_ack();
    test_reset();
    sweeps(16'h0001 << 3, 3);
    do_sweep(16'h0001 << 3, 16'h0003, SWEEP);
    if (key_pending !== 1'b0 || key_valid !== 1'b1) begin
      $display("FAIL ack: got pend=%b valid=%b want 0 1", key_pending, key_valid);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_reset_mid();
    test_reset();
    sweeps(16'h0001 << 12, 4);
    sweeps(16'h0000, 2);
    do_sweep(16'h0001 << 12, 16'h0000, 6);
    test_reset();
    obs_strobes = 0;
    sweeps(16'h0001 << 12, 4);
    if (obs_strobes != 1 || key_code !== 4'd12) begin
      $display("FAIL reset_mid reaccept: got strobes=%0d code=%0d want 1 12", obs_strobes, key_code);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_random();
    logic [15:0] mask;
    logic [15:0] ack;
    int          sel, hold;
    test_reset();
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3)
        mask = 16'h0000;
      else if (sel < 8)
        mask = 16'h0001 << $urandom_range(0, 15);
      else
        mask = (16'h0001 << $urandom_range(0, 7)) | (16'h0100 << $urandom_range(0, 7));
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) begin
        ack = ($urandom_range(0, 2) == 0) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
        do_sweep(mask, ack, SWEEP);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_idle();
    test_single_press();
    test_bounce();
    test_multi();
    test_ack();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
